// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding a UART transmitter over valid/ready.
// Optional registered almost-full flag o_afull is compiled in with `define UART_TX_FIFO_AFULL_EN.
module uart_tx_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_valid,
  input  logic [DATA_W-1:0]        i_wr_data,
  output logic                     o_wr_ready,
  output logic                     o_rd_valid,
  output logic [DATA_W-1:0]        o_rd_data,
  input  logic                     i_rd_ready,
  output logic [$clog2(DEPTH):0]   o_count
`ifdef UART_TX_FIFO_AFULL_EN
  ,
  output logic                     o_afull
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT  = PW'(DEPTH);
  localparam logic [PW-1:0] ZERO_CNT  = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_CNT   = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_TH);

  // Parameter sanity checks at elaboration time.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if ((AFULL_TH < 1) || (AFULL_CNT > FULL_CNT)) begin : g_bad_afull
    $error("uart_tx_fifo: AFULL_TH must lie in 1..DEPTH");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_q,  count_d;
  logic              ptr_empty_s;
  logic              ptr_full_s;
  logic              wr_en_s;
  logic              rd_en_s;
`ifdef UART_TX_FIFO_AFULL_EN
  logic              afull_q;
`endif

  // Wrap bit distinguishes full from empty when the index bits match.
  assign ptr_empty_s = (wr_ptr_q == rd_ptr_q);
  assign ptr_full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign o_wr_ready = (count_q != FULL_CNT);
  assign o_rd_valid = (count_q != ZERO_CNT);
  assign o_rd_data  = o_rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : {DATA_W{1'b0}};
  assign o_count    = count_q;
`ifdef UART_TX_FIFO_AFULL_EN
  assign o_afull    = afull_q;
`endif

  // Next-state pointers and occupancy from the accepted handshakes.
  always_comb begin
    wr_en_s  = 1'b0;
    rd_en_s  = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_en_s  = i_wr_valid && !ptr_full_s;
    rd_en_s  = i_rd_ready && !ptr_empty_s;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + ONE_CNT;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + ONE_CNT;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, occupancy and optional almost-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= ZERO_CNT;
      rd_ptr_q <= ZERO_CNT;
      count_q  <= ZERO_CNT;
`ifdef UART_TX_FIFO_AFULL_EN
      afull_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef UART_TX_FIFO_AFULL_EN
      afull_q  <= (count_d >= AFULL_CNT);
`endif
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table plus directed multi-cycle sequences.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       i_wr_valid;
  logic [7:0] i_wr_data;
  logic       o_wr_ready;
  logic       o_rd_valid;
  logic [7:0] o_rd_data;
  logic       i_rd_ready;
  logic [4:0] o_count;
`ifdef UART_TX_FIFO_AFULL_EN
  logic       o_afull;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] model_q [$];

  uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_TH(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_wr_ready (o_wr_ready),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .i_rd_ready (i_rd_ready),
    .o_count    (o_count)
`ifdef UART_TX_FIFO_AFULL_EN
    ,
    .o_afull    (o_afull)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One clock with model update; got is the head word seen before the edge.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr,
                      output logic took, output logic [7:0] got);
    logic acc_w;
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_rd_ready = rr;
    acc_w = wv && (model_q.size() < 16);
    took  = rr && (model_q.size() > 0);
    got   = o_rd_data;
    @(posedge clk);
    #1;
    if (took) void'(model_q.pop_front());
    if (acc_w) model_q.push_back(wd);
    chk("step_count", int'(o_count), model_q.size());
    chk("step_rd_valid", int'(o_rd_valid), int'(model_q.size() > 0));
    chk("step_rd_data", int'(o_rd_data), (model_q.size() > 0) ? int'(model_q[0]) : 0);
    chk("step_wr_ready", int'(o_wr_ready), int'(model_q.size() < 16));
`ifdef UART_TX_FIFO_AFULL_EN
    chk("step_afull", int'(o_afull), int'(model_q.size() >= 12));
`endif
  endtask

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    int         cnt;
    logic       rv;
    logic [7:0] rd;
    logic       wrdy;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic       took;
    logic [7:0] got;
    logic [7:0] exp_drain [15];
    int         nwr;
    int         nrd;

    for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{1'b1, 8'hA5, 1'b0, 1, 1'b1, 8'hA5, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'hA5, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11, 1'b1};
    vecs[9]  = '{1'b1, 8'h22, 1'b1, 1, 1'b1, 8'h22, 1'b1};
    vecs[10] = '{1'b1, 8'h33, 1'b1, 1, 1'b1, 8'h33, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};
    vecs[12] = '{1'b1, 8'h44, 1'b1, 1, 1'b1, 8'h44, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};

    rst = 1'b1;
    i_wr_valid = 1'b0;
    i_wr_data  = 8'h00;
    i_rd_ready = 1'b0;
    #12;
    chk("reset_count", int'(o_count), 0);
    chk("reset_rd_valid", int'(o_rd_valid), 0);
    chk("reset_rd_data", int'(o_rd_data), 0);
    chk("reset_wr_ready", int'(o_wr_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven vectors, starting from empty and ending empty.
    for (int i = 0; i < 15; i++) begin
      i_wr_valid = vecs[i].wv;
      i_wr_data  = vecs[i].wd;
      i_rd_ready = vecs[i].rr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), int'(o_count), vecs[i].cnt);
      chk($sformatf("vec%0d_rd_valid", i), int'(o_rd_valid), int'(vecs[i].rv));
      chk($sformatf("vec%0d_rd_data", i), int'(o_rd_data), int'(vecs[i].rd));
      chk($sformatf("vec%0d_wr_ready", i), int'(o_wr_ready), int'(vecs[i].wrdy));
    end

    // Fill to full, attempt overflow, then drain in order.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, took, got);
    chk("full_count", int'(o_count), 16);
    chk("full_wr_ready", int'(o_wr_ready), 0);
    step(1'b1, 8'hFF, 1'b0, took, got);
    chk("overflow_count", int'(o_count), 16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, took, got);
      chk("drain_took", int'(took), 1);
      chk("drain_data", int'(got), i);
    end
    chk("drained_count", int'(o_count), 0);
    chk("drained_rd_valid", int'(o_rd_valid), 0);

    // Simultaneous read+write at count 5, then read+write while full.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, took, got);
    chk("sim5_head_before", int'(o_rd_data), 8'h50);
    step(1'b1, 8'h55, 1'b1, took, got);
    chk("sim5_read_data", int'(got), 8'h50);
    chk("sim5_count", int'(o_count), 5);
    chk("sim5_head_after", int'(o_rd_data), 8'h51);
    for (int i = 0; i < 11; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, took, got);
    chk("sim16_count", int'(o_count), 16);
    step(1'b1, 8'hEE, 1'b1, took, got);
    chk("full_rw_read_data", int'(got), 8'h51);
    chk("full_rw_count", int'(o_count), 15);
    chk("full_rw_wr_ready", int'(o_wr_ready), 1);
    exp_drain[0] = 8'h52;
    exp_drain[1] = 8'h53;
    exp_drain[2] = 8'h54;
    exp_drain[3] = 8'h55;
    for (int i = 0; i < 11; i++) exp_drain[4 + i] = 8'h60 + 8'(i);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b1, took, got);
      chk("full_rw_drain", int'(got), int'(exp_drain[i]));
    end
    chk("full_rw_empty", int'(o_count), 0);

    // Wrap-around with random valid/ready, 40 incrementing words.
    nwr = 0;
    nrd = 0;
    for (int cyc = 0; cyc < 800 && nrd < 40; cyc++) begin
      step((nwr < 40) && ($urandom_range(0, 2) != 0), 8'(nwr), ($urandom_range(0, 2) == 0), took, got);
      if (took) begin
        chk("wrap_order", int'(got), nrd);
        nrd++;
      end
      if ((model_q.size() > 0) && (model_q[model_q.size() - 1] == 8'(nwr)) && (nwr < 40)) nwr++;
    end
    chk("wrap_reads_done", nrd, 40);
    chk("wrap_writes_done", nwr, 40);

`ifdef UART_TX_FIFO_AFULL_EN
    // Almost-full flag rises with the 12th word and falls on the next read.
    for (int i = 0; i < 11; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, took, got);
    chk("afull_at11", int'(o_afull), 0);
    step(1'b1, 8'h8B, 1'b0, took, got);
    chk("afull_at12", int'(o_afull), 1);
    step(1'b1, 8'h8C, 1'b1, took, got);
    chk("afull_rw12", int'(o_afull), 1);
    step(1'b0, 8'h00, 1'b1, took, got);
    chk("afull_drop", int'(o_afull), 0);
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, took, got);
`endif

    // Asynchronous reset mid-cycle at count 7, with a burst still driving.
    for (int i = 0; i < 7; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, took, got);
    chk("prereset_count", int'(o_count), 7);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_count", int'(o_count), 0);
    chk("async_rst_rd_valid", int'(o_rd_valid), 0);
    chk("async_rst_rd_data", int'(o_rd_data), 0);
    chk("async_rst_wr_ready", int'(o_wr_ready), 1);
`ifdef UART_TX_FIFO_AFULL_EN
    chk("async_rst_afull", int'(o_afull), 0);
`endif
    i_wr_valid = 1'b1;
    i_rd_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("in_rst_ignore_count", int'(o_count), 0);
    rst = 1'b0;
    model_q.delete();
    step(1'b0, 8'h00, 1'b0, took, got);
    step(1'b1, 8'h3C, 1'b0, took, got);
    chk("post_rst_head", int'(o_rd_data), 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
